// File: rtl/gt_mem_pkg.sv
// rtl/gt_mem_pkg.sv - shared constants and types for the GT line memory responder
package gt_mem_pkg;

  localparam int LINE_W   = 256;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 5;

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/gt_line_ram.sv
// rtl/gt_line_ram.sv - line storage with one synchronous write port and one registered read port
module gt_line_ram #(
  parameter int IDX_W  = 10,
  parameter int LINE_W = 256
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [LINE_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [LINE_W-1:0] o_rdata
);

  logic [LINE_W-1:0] r_mem [2**IDX_W];
  logic [LINE_W-1:0] r_rdata;

  // No reset: contents survive a controller reset.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/gt_line_mem_responder.sv
// rtl/gt_line_mem_responder.sv - fixed-latency, single-outstanding line memory for the GT cache
module gt_line_mem_responder #(
  parameter int LINE_W  = gt_mem_pkg::LINE_W,
  parameter int ADDR_W  = gt_mem_pkg::ADDR_W,
  parameter int IDX_W   = 10,
  parameter int LATENCY = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [LINE_W-1:0] resp_data,
  output logic              resp_write,
  output logic              resp_err
);

  import gt_mem_pkg::*;

  state_t            r_state;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic              r_resp_write;
  logic              r_resp_err;
  logic              r_rd_ok;
  logic [7:0]        r_cnt;

  logic              w_accept;
  logic              w_err;
  logic              w_resp_hs;
  logic [IDX_W-1:0]  w_idx;
  logic [LINE_W-1:0] w_ram_rdata;
  logic              w_unused_offset;

  assign w_accept  = (r_state == IDLE) && r_req_ready && req_valid;
  assign w_err     = |req_addr[ADDR_W-1:OFFSET_W+IDX_W];
  assign w_idx     = req_addr[OFFSET_W+IDX_W-1:OFFSET_W];
  assign w_resp_hs = r_resp_valid && resp_ready;
  assign w_unused_offset = ^req_addr[OFFSET_W-1:0];

  gt_line_ram #(
    .IDX_W  (IDX_W),
    .LINE_W (LINE_W)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_accept && req_write && !w_err),
    .i_waddr (w_idx),
    .i_wdata (req_wdata),
    .i_re    (w_accept && !req_write && !w_err),
    .i_raddr (w_idx),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_write <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rd_ok      <= 1'b0;
      r_cnt        <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req_ready  <= 1'b0;
            r_resp_write <= req_write;
            r_resp_err   <= w_err;
            r_rd_ok      <= !req_write && !w_err;
            r_cnt        <= 8'(LATENCY - 1);
            if (LATENCY == 1) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
            end else begin
              r_state <= WAIT;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (w_resp_hs) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_rd_ok      <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The RAM read register holds the fill line; it is only exposed for a valid read response.
  assign resp_data  = (r_resp_valid && r_rd_ok) ? w_ram_rdata : '0;
  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_write = r_resp_write;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_gt_line_mem_responder.sv
// tb/tb_gt_line_mem_responder.sv - directed scoreboard bench for gt_line_mem_responder
module tb_gt_line_mem_responder;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic         sel = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_write = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [255:0] req_wdata = '0;
  logic         resp_ready = 1'b0;

  logic         rr4, rv4, rw4, re4, rr1, rv1, rw1, re1;
  logic [255:0] rd4, rd1;
  logic         a_req_ready, a_resp_valid, a_resp_write, a_resp_err;
  logic [255:0] a_resp_data;

  gt_line_mem_responder #(.LATENCY(4)) u_dut4 (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid && !sel), .req_ready(rr4), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv4), .resp_ready(resp_ready), .resp_data(rd4),
    .resp_write(rw4), .resp_err(re4)
  );

  gt_line_mem_responder #(.LATENCY(1)) u_dut1 (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid && sel), .req_ready(rr1), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_ready(resp_ready), .resp_data(rd1),
    .resp_write(rw1), .resp_err(re1)
  );

  assign a_req_ready  = sel ? rr1 : rr4;
  assign a_resp_valid = sel ? rv1 : rv4;
  assign a_resp_data  = sel ? rd1 : rd4;
  assign a_resp_write = sel ? rw1 : rw4;
  assign a_resp_err   = sel ? re1 : re4;

  typedef struct packed {
    logic         w;
    logic         e;
    logic [255:0] d;
  } exp_t;

  exp_t         sb[$];
  logic [255:0] model [int];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [255:0] d);
    exp_t e;
    int   idx;
    bit   got = 0;
    @(negedge CLK);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    for (int i = 0; i < 40; i++) begin
      if (a_req_ready) begin got = 1; break; end
      @(negedge CLK);
    end
    chk("accept", 256'(got), 256'd1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    acc_cyc = cyc;
    if (got) begin
      idx = int'(a[14:5]);
      e.w = w;
      e.e = (a[31:15] != 17'd0);
      e.d = (w || e.e) ? 256'd0 : model[idx];
      if (w && !e.e) model[idx] = d;
      sb.push_back(e);
    end
  endtask

  task automatic get_resp(input int hold, input int exp_lat, input bit stray);
    exp_t         e;
    bit           got = 0;
    logic [255:0] d0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (a_resp_valid) begin got = 1; break; end
    end
    chk("resp_seen", 256'(got), 256'd1);
    if (got) begin
      chk("latency", 256'(cyc - acc_cyc + 1), 256'(exp_lat));
      if (sb.size() == 0) begin
        chk("sb_nonempty", 256'd0, 256'd1);
        e = '0;
      end else begin
        e = sb.pop_front();
      end
      chk("resp_data", a_resp_data, e.d);
      chk("resp_write", 256'(a_resp_write), 256'(e.w));
      chk("resp_err", 256'(a_resp_err), 256'(e.e));
      d0 = a_resp_data;
      for (int i = 0; i < hold; i++) begin
        if (stray && i == 0) begin
          req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40;
        end
        @(negedge CLK);
        chk("hold_valid", 256'(a_resp_valid), 256'd1);
        chk("hold_data", a_resp_data, d0);
        chk("hold_req_ready", 256'(a_req_ready), 256'd0);
      end
      resp_ready = 1'b1;
      @(posedge CLK); #1;
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      chk("post_valid", 256'(a_resp_valid), 256'd0);
      chk("post_data", a_resp_data, 256'd0);
      chk("post_req_ready", 256'(a_req_ready), 256'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a1, a2, a3;
    // reset held three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rst_req_ready", 256'(a_req_ready), 256'd0);
      chk("rst_resp_valid", 256'(a_resp_valid), 256'd0);
      chk("rst_resp_data", a_resp_data, 256'd0);
      chk("rst_resp_write", 256'(a_resp_write), 256'd0);
      chk("rst_resp_err", 256'(a_resp_err), 256'd0);
    end
    RST = 1'b0;
    #1 chk("rel_req_ready_low", 256'(a_req_ready), 256'd0);
    @(negedge CLK);
    chk("rel_req_ready_high", 256'(a_req_ready), 256'd1);

    // write then read, offset ignored
    issue(1'b1, 32'h0000_0040, {32{8'hA5}});
    get_resp(0, 4, 1'b0);
    issue(1'b0, 32'h0000_0047, '0);
    get_resp(0, 4, 1'b0);

    // backpressure with a second request held pending
    issue(1'b1, 32'h0000_0000, {32{8'h11}});
    get_resp(0, 4, 1'b0);
    issue(1'b0, 32'h0000_0047, '0);
    get_resp(6, 4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("no_stray_resp", 256'(a_resp_valid), 256'd0);
    end

    // out-of-range read and write; line 0 untouched
    issue(1'b0, 32'h0001_0000, '0);
    get_resp(0, 4, 1'b0);
    issue(1'b1, 32'h0001_0000, {32{8'hFF}});
    get_resp(0, 4, 1'b0);
    issue(1'b0, 32'h0000_0000, '0);
    get_resp(0, 4, 1'b0);

    // reset during WAIT abandons the response but keeps the write
    issue(1'b1, 32'h0000_00A0, {32{8'h3C}});
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("midrst_valid", 256'(a_resp_valid), 256'd0);
    chk("midrst_req_ready", 256'(a_req_ready), 256'd0);
    void'(sb.pop_front());
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("midrst_no_resp", 256'(a_resp_valid), 256'd0);
    end
    issue(1'b0, 32'h0000_00A0, '0);
    get_resp(0, 4, 1'b0);

    // LATENCY=1 instance: back-to-back reads every 2 cycles
    sel = 1'b1;
    issue(1'b1, 32'h0000_0100, {32{8'h5A}});
    get_resp(0, 1, 1'b0);
    issue(1'b0, 32'h0000_0100, '0);
    a1 = acc_cyc;
    get_resp(0, 1, 1'b0);
    issue(1'b0, 32'h0000_0100, '0);
    a2 = acc_cyc;
    get_resp(0, 1, 1'b0);
    issue(1'b0, 32'h0000_0105, '0);
    a3 = acc_cyc;
    get_resp(0, 1, 1'b0);
    chk("l1_spacing_a", 256'(a2 - a1), 256'd2);
    chk("l1_spacing_b", 256'(a3 - a2), 256'd2);
    chk("sb_drained", 256'(sb.size()), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
